// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Handshake bundle around the fetch stage. It carries the
//               instruction-memory request/response channel, the decode-side
//               instruction channel and the branch redirect input.
//               master  : the fetch unit
//               slave   : the memory / decode / branch environment
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
) ();
    // instruction memory request
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    // instruction memory response (in order)
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    // decode channel
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic [10:0]            opcode;
    // branch redirect
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output instr_valid, instr, instr_pc, opcode,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  instr_valid, instr, instr_pc, opcode,
        output instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues in-order fetch
//               requests, buffers returned words in a small FIFO and hands
//               them to decode. Branch redirects flush the FIFO and discard
//               every response still owed by memory for the wrong path.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-high reset
//               bus    - fetch_unit_if.master (imem req/resp, instr, redirect)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    DEPTH       = 2
) (
    input  wire          clk,
    input  wire          reset,
    fetch_unit_if.master bus
);

    localparam int                    c_PTR_W      = $clog2(DEPTH);
    localparam int                    c_CNT_W      = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0]    c_DEPTH      = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(3);

    localparam logic [0:0] c_ST_FETCH = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    logic [0:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [c_CNT_W-1:0]     r_outstanding;
    logic [c_CNT_W-1:0]     r_drop;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_aq_rd;
    logic [c_PTR_W-1:0]     r_aq_wr;
    logic [ADDR_WIDTH-1:0]  r_aq        [DEPTH];
    logic [INSTR_WIDTH-1:0] r_fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_fifo_pc   [DEPTH];

    logic [c_CNT_W-1:0]     w_inflight;
    logic                   w_req_valid;
    logic                   w_req_fire;
    logic                   w_resp_fire;
    logic                   w_instr_valid;
    logic                   w_pop;
    logic                   w_push;
    logic [c_CNT_W-1:0]     w_out_next;
    logic [c_CNT_W-1:0]     w_drop_next;
    logic [ADDR_WIDTH-1:0]  w_redirect_pc;

    always_comb begin
        // Buffered plus owed words never exceed DEPTH, so a response always
        // has a FIFO slot and the sum cannot overflow c_CNT_W.
        w_inflight    = r_count + r_outstanding;
        // Gated with reset so no request is shown while reset is held.
        w_req_valid   = ~reset & (r_state == c_ST_FETCH) & ~bus.redirect_valid
                        & (w_inflight < c_DEPTH);
        w_req_fire    = w_req_valid & bus.imem_req_ready;
        // A response with nothing owed is stale (e.g. from before a reset).
        w_resp_fire   = bus.imem_resp_valid & (r_outstanding != '0);
        w_instr_valid = (r_state == c_ST_FETCH) & (r_count != '0);
        w_pop         = w_instr_valid & bus.instr_ready;
        w_push        = w_resp_fire & (r_drop == '0) & ~bus.redirect_valid;
        w_redirect_pc = bus.redirect_pc & c_ALIGN_MASK;

        w_out_next = r_outstanding;
        if (w_req_fire) begin
            w_out_next = w_out_next + c_CNT_ONE;
        end
        if (w_resp_fire) begin
            w_out_next = w_out_next - c_CNT_ONE;
        end

        // On redirect every response still owed after this edge belongs to
        // the wrong path; a response returning this cycle is discarded too.
        w_drop_next = r_drop;
        if (bus.redirect_valid) begin
            w_drop_next = w_out_next;
        end else if (w_resp_fire && (r_drop != '0)) begin
            w_drop_next = r_drop - c_CNT_ONE;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr          = r_fifo_data[r_rd_ptr];
    assign bus.instr_pc       = r_fifo_pc[r_rd_ptr];
    assign bus.opcode         = r_fifo_data[r_rd_ptr][31:21];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_FETCH;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_aq[i]        <= '0;
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else begin
            r_outstanding <= w_out_next;
            r_drop        <= w_drop_next;

            // The address queue tracks memory order and is never flushed:
            // dropped responses still retire their entry.
            if (w_req_fire) begin
                r_aq[r_aq_wr] <= r_pc;
                r_aq_wr       <= r_aq_wr + c_PTR_ONE;
            end
            if (w_resp_fire) begin
                r_aq_rd <= r_aq_rd + c_PTR_ONE;
            end

            if (bus.redirect_valid) begin
                // Any same-cycle decode handshake is simply absorbed by the
                // flush; nothing is pushed on a redirect cycle.
                r_pc     <= w_redirect_pc;
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
                r_state  <= (w_drop_next != '0) ? c_ST_FLUSH : c_ST_FETCH;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + c_PC_STEP;
                end
                if (w_push) begin
                    r_fifo_data[r_wr_ptr] <= bus.imem_resp_data;
                    r_fifo_pc[r_wr_ptr]   <= r_aq[r_aq_rd];
                    r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_ONE;
                end
                if ((r_state == c_ST_FLUSH) && (w_drop_next == '0)) begin
                    r_state <= c_ST_FETCH;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready interface.
- Buffers returned instruction words in a small FIFO and presents them to decode with a valid/ready handshake; `opcode` (instr[31:21]) drives the control decoder.
- Accepts branch redirects from the execute/branch logic and discards wrong-path fetches.

Parameters:
- ADDR_WIDTH, 64, PC and memory address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, FIFO entries and maximum outstanding requests combined (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  fetch address (= PC).
- imem_resp_valid  in  1  response word valid; in order, >=1 cycle after acceptance.
- imem_resp_data  in  INSTR_WIDTH  response instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  INSTR_WIDTH  head instruction word.
- instr_pc  out  ADDR_WIDTH  PC of head instruction.
- opcode  out  11  instr[31:21], to control decoder.
- redirect_valid  in  1  branch taken / PC override.
- redirect_pc  in  ADDR_WIDTH  new PC; bits [1:0] forced to 0.

Behaviour:
- Reset (async): PC=RESET_PC, FIFO empty, outstanding=0, drop=0, state=FETCH. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, opcode=0.
- States: FETCH, FLUSH.
- FETCH:
  - imem_req_valid=1 when occupancy+outstanding < DEPTH and redirect_valid=0.
  - On request handshake: PC += 4 (wraps modulo 2^ADDR_WIDTH), outstanding += 1, and the address is pushed to an internal address queue.
- Response handling:
  - Each imem_resp_valid pops the address queue and outstanding -= 1.
  - If drop>0, the response is discarded and drop -= 1; otherwise {data, addr} is written to the FIFO.
  - A response arriving with outstanding=0 is ignored.
- Latency: request accepted in cycle N, response in cycle N+k, instr_valid=1 in cycle N+k+1 (registered FIFO output). No combinational path from imem_resp_* to instr_*.
- Decode handshake: head pops when instr_valid & instr_ready. instr, instr_pc and opcode are stable while instr_valid=1 and instr_ready=0. Simultaneous push and pop with a full FIFO is legal.
- Redirect (any state), applied at the clock edge:
  - PC = {redirect_pc[ADDR_WIDTH-1:2],2'b00} and the FIFO is flushed.
  - drop = outstanding after this cycle's accept and return, so same-cycle accepted requests are dropped and a same-cycle response is discarded.
  - Go to FLUSH if the new drop>0, else stay in FETCH.
  - A same-cycle instr handshake is honoured (decode took the word); the FIFO is still emptied.
  - imem_req_valid is 0 during the redirect cycle. Requests may be withdrawn on redirect, which our memory permits.
- FLUSH:
  - No requests are issued and instr_valid=0.
  - Return to FETCH when drop reaches 0; the first new request issues the cycle after.
  - A further redirect in FLUSH updates PC and keeps draining.
- Mid-operation reset: all state is cleared immediately; in-flight responses after reset are ignored because outstanding=0.
- Backpressure: with FIFO full and instr_ready=0, no requests issue.

Test Plan:
- Reset release, RESET_PC=0x100, memory always ready, 1-cycle latency -> requests to 0x100, 0x104, 0x108…; instr_valid first rises 2 cycles after first acceptance; instr_pc matches each word; opcode = instr[31:21] (0x458 for ADD).
- instr_ready held 0 for 10 cycles -> at most DEPTH=2 outstanding+buffered words; imem_req_valid=0 while full; head stable; on release, words arrive in order with no loss or duplication.
- Redirect to 0x2003 with 2 outstanding, 3-cycle memory latency -> both responses discarded; FLUSH for 3 cycles; next request address 0x2000; first instr_pc=0x2000.
- Redirect coincident with a response and with a request handshake -> both dropped; drop count correct; no stale word ever reaches instr.
- Reset asserted while 1 request is outstanding, response arrives during reset and 1 cycle after -> ignored; fetch restarts at RESET_PC.
- PC=0xFFFF_FFFF_FFFF_FFFC fetch -> next request address 0x0 (wrap).
